// File: rtl/l1_threshold_servo_if.sv
// Bus bundle between the L1 threshold servo and its controller / beamform_trigger.
// The servo uses the slave modport; whoever drives the control inputs uses master.
interface l1_threshold_servo_if #(
    parameter int unsigned NBEAMS = 2
);
    localparam int unsigned THR_W = 18;
    localparam int unsigned CNT_W = 32;
    localparam int unsigned TOL_W = 16;

    logic                      enable_i;
    logic                      init_i;
    logic [THR_W-1:0]          thresh_init_i;
    logic [CNT_W-1:0]          target_i;
    logic [TOL_W-1:0]          tol_i;
    logic [THR_W-1:0]          step_i;
    logic [NBEAMS-1:0]         trigger_i;
    logic [THR_W-1:0]          thresh_o;
    logic [NBEAMS-1:0]         thresh_ce_o;
    logic                      update_o;
    logic                      busy_o;
    logic                      done_o;
    logic [NBEAMS*CNT_W-1:0]   count_o;
    logic [NBEAMS*THR_W-1:0]   thresh_rb_o;

    modport master (
        output enable_i, init_i, thresh_init_i, target_i, tol_i, step_i, trigger_i,
        input  thresh_o, thresh_ce_o, update_o, busy_o, done_o, count_o, thresh_rb_o
    );

    modport slave (
        input  enable_i, init_i, thresh_init_i, target_i, tol_i, step_i, trigger_i,
        output thresh_o, thresh_ce_o, update_o, busy_o, done_o, count_o, thresh_rb_o
    );
endinterface

// File: rtl/l1_threshold_servo.sv
// Closed-loop per-beam threshold servo for the L1 beamform trigger: load, commit, settle,
// count holdoff-gated triggers over a window, then step each threshold toward a target rate.
module l1_threshold_servo #(
    parameter int unsigned NBEAMS         = 2,
    parameter int unsigned PERIOD_CLOCKS  = 375000,
    parameter int unsigned SETTLE_CLOCKS  = 32,
    parameter int unsigned HOLDOFF_CLOCKS = 16,
    parameter logic [17:0] THRESH_MAX     = 18'h3FFFF
) (
    input logic                 aclk,
    input logic                 aresetn,
    l1_threshold_servo_if.slave bus
);
    localparam int unsigned THR_W  = 18;
    localparam int unsigned SUM_W  = THR_W + 1;
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned CMP_W  = CNT_W + 1;
    localparam int unsigned TMR_W  = 32;
    localparam int unsigned HOLD_W = 32;
    localparam int unsigned IDX_W  = (NBEAMS > 1) ? $clog2(NBEAMS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBEAMS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_UPDATE,
        S_SETTLE,
        S_COUNT,
        S_ADJUST,
        S_DONE
    } state_t;

    state_t                  state;
    logic [IDX_W-1:0]        idx;
    logic [TMR_W-1:0]        timer;
    logic [THR_W-1:0]        thr  [NBEAMS];
    logic [CNT_W-1:0]        cnt  [NBEAMS];
    logic [HOLD_W-1:0]       hold [NBEAMS];

    logic [THR_W-1:0]        thresh_q;
    logic [NBEAMS-1:0]       ce_q;
    logic                    update_q;
    logic                    busy_q;
    logic                    done_q;
    logic [NBEAMS*CNT_W-1:0] count_q;

    logic [IDX_W-1:0]        next_idx;
    logic [CNT_W-1:0]        cnt_sel;
    logic [THR_W-1:0]        thr_sel;
    logic [CMP_W-1:0]        upper;
    logic [CMP_W-1:0]        cnt_plus_tol;
    logic [SUM_W-1:0]        sum;
    logic                    go_up;
    logic                    go_down;
    logic [THR_W-1:0]        adj_thr;

    // Threshold step decision for the beam currently addressed in ADJUST.
    always_comb begin
        next_idx     = idx + IDX_W'(1);
        cnt_sel      = cnt[idx];
        thr_sel      = thr[idx];
        upper        = CMP_W'(bus.target_i) + CMP_W'(bus.tol_i);
        cnt_plus_tol = CMP_W'(cnt_sel) + CMP_W'(bus.tol_i);
        go_up        = CMP_W'(cnt_sel) > upper;
        go_down      = cnt_plus_tol < CMP_W'(bus.target_i);
        sum          = SUM_W'(thr_sel) + SUM_W'(bus.step_i);
        adj_thr      = thr_sel;
        if (go_up) begin
            adj_thr = (sum > SUM_W'(THRESH_MAX)) ? THRESH_MAX : sum[THR_W-1:0];
        end else if (go_down) begin
            adj_thr = (thr_sel < bus.step_i) ? '0 : (thr_sel - bus.step_i);
        end
    end

    // Iteration sequencer; outputs are registered alongside the state they belong to.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= S_IDLE;
            idx      <= '0;
            timer    <= '0;
            thresh_q <= '0;
            ce_q     <= '0;
            update_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            count_q  <= '0;
            for (int b = 0; b < NBEAMS; b++) begin
                thr[b]  <= '0;
                cnt[b]  <= '0;
                hold[b] <= '0;
            end
        end else begin
            update_q <= 1'b0;
            done_q   <= 1'b0;
            ce_q     <= '0;
            case (state)
                S_IDLE: begin
                    if (bus.init_i) begin
                        for (int b = 0; b < NBEAMS; b++) begin
                            thr[b] <= bus.thresh_init_i;
                        end
                    end else if (bus.enable_i) begin
                        state    <= S_LOAD;
                        idx      <= '0;
                        thresh_q <= thr[0];
                        ce_q     <= NBEAMS'(1);
                        busy_q   <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (idx == LAST_IDX) begin
                        state    <= S_UPDATE;
                        update_q <= 1'b1;
                    end else begin
                        idx      <= next_idx;
                        thresh_q <= thr[next_idx];
                        ce_q     <= NBEAMS'(1) << next_idx;
                    end
                end
                S_UPDATE: begin
                    state <= S_SETTLE;
                    timer <= TMR_W'(SETTLE_CLOCKS - 1);
                    for (int b = 0; b < NBEAMS; b++) begin
                        cnt[b]  <= '0;
                        hold[b] <= '0;
                    end
                end
                S_SETTLE: begin
                    for (int b = 0; b < NBEAMS; b++) begin
                        cnt[b]  <= '0;
                        hold[b] <= '0;
                    end
                    if (timer == '0) begin
                        state <= S_COUNT;
                        timer <= TMR_W'(PERIOD_CLOCKS - 1);
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                S_COUNT: begin
                    // Holdoff-gated, saturating per-beam trigger counters.
                    for (int b = 0; b < NBEAMS; b++) begin
                        if (bus.trigger_i[b] && (hold[b] == '0)) begin
                            if (cnt[b] != '1) begin
                                cnt[b] <= cnt[b] + CNT_W'(1);
                            end
                            hold[b] <= HOLD_W'(HOLDOFF_CLOCKS);
                        end else if (hold[b] != '0) begin
                            hold[b] <= hold[b] - HOLD_W'(1);
                        end
                    end
                    if (timer == '0) begin
                        state <= S_ADJUST;
                        idx   <= '0;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                S_ADJUST: begin
                    thr[idx] <= adj_thr;
                    if (idx == LAST_IDX) begin
                        state  <= S_DONE;
                        done_q <= 1'b1;
                        for (int b = 0; b < NBEAMS; b++) begin
                            count_q[b*CNT_W +: CNT_W] <= cnt[b];
                        end
                    end else begin
                        idx <= next_idx;
                    end
                end
                S_DONE: begin
                    if (bus.enable_i) begin
                        state    <= S_LOAD;
                        idx      <= '0;
                        thresh_q <= thr[0];
                        ce_q     <= NBEAMS'(1);
                    end else begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.thresh_o    = thresh_q;
    assign bus.thresh_ce_o = ce_q;
    assign bus.update_o    = update_q;
    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.count_o     = count_q;

    for (genvar g = 0; g < NBEAMS; g++) begin : g_rb
        assign bus.thresh_rb_o[g*THR_W +: THR_W] = thr[g];
    end
endmodule
